// File: rtl/bsg_sync_sync_filtered_if.sv
// Data crossing bundle for bsg_sync_sync_filtered.
// The master drives the source data; the slave (the synchronizer) returns the filtered result.
interface bsg_sync_sync_filtered_if #(
  parameter int width_p = 16
);
  logic [width_p-1:0] iclk_data_i;
  logic [width_p-1:0] oclk_data_o;
  logic               changed_o;
  logic               pending_o;

  modport master (output iclk_data_i, input oclk_data_o, changed_o, pending_o);
  modport slave  (input iclk_data_i, output oclk_data_o, changed_o, pending_o);
endinterface

// File: rtl/bsg_sync_sync_filtered.sv
// Multi-stage synchronizer with a stability filter: a synchronized value is committed
// to the output only after it has held for stable_cycles_p consecutive destination edges.
module bsg_sync_sync_filtered #(
  parameter int                 width_p         = 16,
  parameter int                 num_stages_p    = 2,
  parameter int                 stable_cycles_p = 2,
  parameter logic [width_p-1:0] reset_val_p     = '0
) (
  input logic                     clk_i,
  input logic                     reset_i,
  bsg_sync_sync_filtered_if.slave bus
);

  localparam int cnt_w = $clog2(stable_cycles_p + 1);

  if (num_stages_p < 2 || num_stages_p > 4) begin : g_bad_stages
    $error("bsg_sync_sync_filtered: num_stages_p must be in 2..4");
  end
  if (stable_cycles_p < 1 || stable_cycles_p > 255) begin : g_bad_stable
    $error("bsg_sync_sync_filtered: stable_cycles_p must be in 1..255");
  end

  typedef enum logic {IDLE, QUALIFY} state_t;

  localparam logic [cnt_w-1:0] stable_c = cnt_w'(stable_cycles_p);
  localparam logic [cnt_w-1:0] one_c    = cnt_w'(1);

  (* async_reg = "true" *) logic [width_p-1:0] sync_r [num_stages_p];

  logic [width_p-1:0] synced;
  logic [width_p-1:0] cand_r;
  logic [width_p-1:0] data_r;
  logic [cnt_w-1:0]   cnt_r;
  logic [cnt_w-1:0]   cnt_inc;
  logic               changed_r;
  state_t             state_r;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_stages_p; k++) sync_r[k] <= reset_val_p;
    end else begin
      sync_r[0] <= bus.iclk_data_i;
      for (int k = 1; k < num_stages_p; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  assign synced  = sync_r[num_stages_p-1];
  assign cnt_inc = cnt_r + one_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      cand_r    <= reset_val_p;
      data_r    <= reset_val_p;
      changed_r <= 1'b0;
    end else begin
      changed_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (synced != data_r) begin
            if (stable_cycles_p == 1) begin
              data_r    <= synced;
              changed_r <= 1'b1;
            end else begin
              cand_r  <= synced;
              cnt_r   <= one_c;
              state_r <= QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (synced == data_r) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else if (synced != cand_r) begin
            // A different value arrived mid-qualification: restart on it.
            cand_r <= synced;
            cnt_r  <= one_c;
          end else if (cnt_inc == stable_c) begin
            data_r    <= synced;
            changed_r <= 1'b1;
            cnt_r     <= '0;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_inc;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.oclk_data_o = data_r;
  assign bus.changed_o   = changed_r;
  assign bus.pending_o   = (synced != data_r);

endmodule

// File: tb/tb_bsg_sync_sync_filtered.sv
// Directed bench for bsg_sync_sync_filtered across several parameter sets,
// plus a long random-step run on the default configuration.
module tb_bsg_sync_sync_filtered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d, rst_e;
  int   n_checks = 0;
  int   n_errors = 0;

  bsg_sync_sync_filtered_if #(.width_p(16)) if_a ();
  bsg_sync_sync_filtered_if #(.width_p(16)) if_b ();
  bsg_sync_sync_filtered_if #(.width_p(16)) if_c ();
  bsg_sync_sync_filtered_if #(.width_p(16)) if_d ();
  bsg_sync_sync_filtered_if #(.width_p(16)) if_e ();

  bsg_sync_sync_filtered #(.width_p(16)) dut_a (.clk_i(clk), .reset_i(rst_a), .bus(if_a));
  bsg_sync_sync_filtered #(.width_p(16), .num_stages_p(3), .stable_cycles_p(4))
    dut_b (.clk_i(clk), .reset_i(rst_b), .bus(if_b));
  bsg_sync_sync_filtered #(.width_p(16), .num_stages_p(2), .stable_cycles_p(3))
    dut_c (.clk_i(clk), .reset_i(rst_c), .bus(if_c));
  bsg_sync_sync_filtered #(.width_p(16), .reset_val_p(16'hBEEF))
    dut_d (.clk_i(clk), .reset_i(rst_d), .bus(if_d));
  bsg_sync_sync_filtered #(.width_p(16), .num_stages_p(2), .stable_cycles_p(1))
    dut_e (.clk_i(clk), .reset_i(rst_e), .bus(if_e));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           pend_cnt, chg_cnt, first, trans_cnt, hold;
    logic         seen11;
    logic [15:0]  hist[$];
    logic [15:0]  exp_out, prev_exp, cur_in;

    rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1; rst_e = 1;
    if_a.iclk_data_i = 16'h0000;
    if_b.iclk_data_i = 16'h0000;
    if_c.iclk_data_i = 16'h0000;
    if_d.iclk_data_i = 16'hBEEF;
    if_e.iclk_data_i = 16'h0000;
    repeat (3) tick();
    check_val("rst_a_data",    if_a.oclk_data_o, 16'h0000);
    check_val("rst_a_changed", if_a.changed_o,   1'b0);
    check_val("rst_a_pending", if_a.pending_o,   1'b0);
    check_val("rst_d_data",    if_d.oclk_data_o, 16'hBEEF);
    check_val("rst_d_pending", if_d.pending_o,   1'b0);
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0; rst_e = 0;

    // Clean step on the default configuration: commit at edge 3.
    if_a.iclk_data_i = 16'hA5C3;
    tick();
    check_val("a_e0_data",    if_a.oclk_data_o, 16'h0000);
    check_val("a_e0_pending", if_a.pending_o,   1'b0);
    tick();
    check_val("a_e1_data",    if_a.oclk_data_o, 16'h0000);
    check_val("a_e1_pending", if_a.pending_o,   1'b1);
    tick();
    check_val("a_e2_data",    if_a.oclk_data_o, 16'h0000);
    check_val("a_e2_pending", if_a.pending_o,   1'b1);
    check_val("a_e2_changed", if_a.changed_o,   1'b0);
    tick();
    check_val("a_e3_data",    if_a.oclk_data_o, 16'hA5C3);
    check_val("a_e3_changed", if_a.changed_o,   1'b1);
    check_val("a_e3_pending", if_a.pending_o,   1'b0);
    tick();
    check_val("a_e4_changed", if_a.changed_o,   1'b0);
    check_val("a_e4_data",    if_a.oclk_data_o, 16'hA5C3);

    // Short glitch (3 edges) against a 4-edge filter is rejected.
    pend_cnt = 0; chg_cnt = 0;
    if_b.iclk_data_i = 16'h5A5A;
    for (int e = 0; e < 13; e++) begin
      if (e == 3) if_b.iclk_data_i = 16'h0000;
      tick();
      if (if_b.pending_o) pend_cnt++;
      if (if_b.changed_o) chg_cnt++;
      if (if_b.oclk_data_o != 16'h0000) chg_cnt += 100;
    end
    check_val("b_glitch_data",    if_b.oclk_data_o, 16'h0000);
    check_val("b_glitch_changed", chg_cnt,          0);
    check_val("b_glitch_pending", pend_cnt,         3);

    // Back-to-back values: only the final one qualifies (commit at edge 5).
    chg_cnt = 0; seen11 = 1'b0;
    if_c.iclk_data_i = 16'h0011;
    tick();
    if_c.iclk_data_i = 16'h0022;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (if_c.oclk_data_o == 16'h0011) seen11 = 1'b1;
      if (if_c.changed_o) chg_cnt++;
      if (e == 4) check_val("c_e4_data", if_c.oclk_data_o, 16'h0000);
      if (e == 5) check_val("c_e5_data", if_c.oclk_data_o, 16'h0022);
    end
    check_val("c_pulses", chg_cnt, 1);
    check_val("c_seen11", seen11,  1'b0);

    // Reset while qualifying 0x1234 with a non-zero reset value.
    if_d.iclk_data_i = 16'h1234;
    repeat (3) tick();
    check_val("d_qual_data",    if_d.oclk_data_o, 16'hBEEF);
    check_val("d_qual_pending", if_d.pending_o,   1'b1);
    rst_d = 1;
    tick();
    rst_d = 0;
    check_val("d_rst_data",    if_d.oclk_data_o, 16'hBEEF);
    check_val("d_rst_changed", if_d.changed_o,   1'b0);
    check_val("d_rst_pending", if_d.pending_o,   1'b0);
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (first == 0 && if_d.oclk_data_o == 16'h1234) begin
        first = n;
        check_val("d_commit_changed", if_d.changed_o, 1'b1);
      end
    end
    check_val("d_commit_edge", first, 4);

    // Single-cycle filter: commit one edge after the value is synchronized.
    if_e.iclk_data_i = 16'h0001;
    tick();
    check_val("e_e0_data", if_e.oclk_data_o, 16'h0000);
    tick();
    check_val("e_e1_data",    if_e.oclk_data_o, 16'h0000);
    check_val("e_e1_pending", if_e.pending_o,   1'b1);
    tick();
    check_val("e_e2_data",    if_e.oclk_data_o, 16'h0001);
    check_val("e_e2_changed", if_e.changed_o,   1'b1);
    check_val("e_e2_pending", if_e.pending_o,   1'b0);
    tick();
    check_val("e_e3_changed", if_e.changed_o,   1'b0);

    // Random steps held >= 6 edges: output is the input delayed by 3 edges.
    cur_in = 16'hA5C3;
    repeat (3) hist.push_back(cur_in);
    prev_exp = 16'hA5C3;
    hold = 0; chg_cnt = 0; trans_cnt = 0;
    for (int t = 0; t < 10000; t++) begin
      if (hold == 0) begin
        cur_in = 16'($urandom);
        hold   = $urandom_range(6, 12);
      end
      hold--;
      if_a.iclk_data_i = cur_in;
      hist.push_back(cur_in);
      tick();
      exp_out = hist.pop_front();
      check_val("rand_data",    if_a.oclk_data_o, exp_out);
      check_val("rand_changed", if_a.changed_o,   exp_out != prev_exp);
      if (exp_out != prev_exp) trans_cnt++;
      if (if_a.changed_o) chg_cnt++;
      prev_exp = exp_out;
    end
    check_val("rand_pulse_count", chg_cnt, trans_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
